// File: rtl/config_pkg.sv
// Shared definitions for the configuration-menu text writer.
//   state_t            : writer FSM states
//   BUF_COLS/BUF_ROWS  : text buffer geometry (40 x 23 cells)
//   field_row/col      : screen position of each menu field's label
//   cell_addr          : 40*row + col using shift-add arithmetic
//   hex_char           : nibble to ASCII hex digit
package config_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_LABEL  = 3'd2,
    ST_VALUE  = 3'd3,
    ST_UPDATE = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  localparam int          BUF_COLS       = 40;
  localparam int          BUF_ROWS       = 23;
  localparam int          LABEL_LEN      = 8;
  localparam logic [9:0]  VALUE_COL_OFS  = 10'd9;
  localparam logic [7:0]  CHAR_SPACE     = 8'h20;
  localparam logic [7:0]  HEX_DIGIT_BASE = 8'h30;
  localparam logic [7:0]  HEX_ALPHA_BASE = 8'h41;

  // Fields 0..7 form the left column, 8..11 the right column, 12 is START.
  function automatic logic [4:0] field_row(input logic [3:0] f);
    if (f < 4'd8)       return 5'd3 + {1'b0, f[2:0], 1'b0};
    else if (f < 4'd12) return 5'd3 + {2'b00, f[1:0], 1'b0};
    else                return 5'd20;
  endfunction

  function automatic logic [5:0] field_col(input logic [3:0] f);
    if (f < 4'd8)       return 6'd2;
    else if (f < 4'd12) return 6'd22;
    else                return 6'd17;
  endfunction

  function automatic logic [9:0] cell_addr(input logic [4:0] row, input logic [5:0] col);
    logic [9:0] r;
    r = {5'd0, row};
    return (r << 5) + (r << 3) + {4'd0, col};
  endfunction

  function automatic logic [9:0] field_addr(input logic [3:0] f);
    return cell_addr(field_row(f), field_col(f));
  endfunction

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10) return HEX_DIGIT_BASE + {4'd0, n};
    else           return HEX_ALPHA_BASE + {4'd0, n} - 8'd10;
  endfunction

endpackage

// File: rtl/config_label_rom.sv
// Label character ROM: 13 fields x 8 characters, registered read.
//   clk_in   : system clock
//   addr_in  : 7-bit address, field*8 + char
//   data_out : character code, valid the cycle after addr_in is presented
module config_label_rom
  import config_pkg::*;
(
  input  logic       clk_in,
  input  logic [6:0] addr_in,
  output logic [7:0] data_out
);

  function automatic logic [7:0] label_char(input logic [6:0] a);
    logic [63:0] txt;
    case (a[6:3])
      4'd0:    txt = "CH1 GAIN";
      4'd1:    txt = "CH2 GAIN";
      4'd2:    txt = "CH3 GAIN";
      4'd3:    txt = "CH4 GAIN";
      4'd4:    txt = "CH1 PAN ";
      4'd5:    txt = "CH2 PAN ";
      4'd6:    txt = "CH3 PAN ";
      4'd7:    txt = "CH4 PAN ";
      4'd8:    txt = "TEMPO   ";
      4'd9:    txt = "SWING   ";
      4'd10:   txt = "TRANSPOS";
      4'd11:   txt = "MASTER  ";
      default: txt = "START   ";
    endcase
    // Character 0 is the leftmost, i.e. the most significant byte.
    return txt[{~a[2:0], 3'b000} +: 8];
  endfunction

  // NOTE: a ROM read register carries no reset; its content is never
  // consumed before a valid address has been clocked in.
  always_ff @(posedge clk_in) begin
    data_out <= label_char(addr_in);
  end

endmodule

// File: rtl/config_text_writer.sv
// Configuration-menu text writer: clears the 40x23 text buffer, draws the
// field labels and the hex values, and rewrites single values on update.
//   clk_in             : system clock
//   rst_in             : synchronous reset, active-low
//   redraw_in          : pulse, request full redraw
//   update_in          : pulse, store field_value_in into field_index_in
//   field_index_in     : field index (values 0..11 are editable)
//   field_value_in     : new 8-bit field value
//   buf_write_en_out   : text-buffer write strobe
//   buf_write_addr_out : cell address, 40*row + col
//   buf_write_data_out : character code
//   busy_out           : high during write cycles of a sequence
//   done_out           : one-cycle pulse after each sequence
module config_text_writer
  import config_pkg::*;
#(
  parameter int NUM_VALUE_FIELDS = 12,
  parameter int NUM_FIELDS       = 13
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       redraw_in,
  input  logic       update_in,
  input  logic [3:0] field_index_in,
  input  logic [7:0] field_value_in,
  output logic       buf_write_en_out,
  output logic [9:0] buf_write_addr_out,
  output logic [7:0] buf_write_data_out,
  output logic       busy_out,
  output logic       done_out
);

  localparam logic [9:0] CLEAR_LAST = 10'(BUF_COLS * BUF_ROWS - 1);
  localparam logic [9:0] LABEL_LAST = 10'(NUM_FIELDS * LABEL_LEN - 1);
  localparam logic [9:0] VALUE_LAST = 10'(NUM_VALUE_FIELDS * 2 - 1);
  localparam logic [3:0] NUM_VF     = 4'(NUM_VALUE_FIELDS);
  localparam logic [NUM_VALUE_FIELDS-1:0] ONE = {{(NUM_VALUE_FIELDS-1){1'b0}}, 1'b1};

  state_t                      state, state_nx;
  logic [9:0]                  cnt, cnt_nx;
  logic [3:0]                  upd_field, upd_field_nx;
  logic [NUM_VALUE_FIELDS-1:0] mask, mask_nx, eff_mask;
  logic                        redraw_pend, redraw_pend_nx, eff_redraw;
  logic [7:0]                  value_file [NUM_VALUE_FIELDS];
  logic                        update_ok;
  logic [3:0]                  pick, f;
  logic                        en_nx, busy_nx, done_nx;
  logic [9:0]                  addr_nx;
  logic [7:0]                  data_nx;
  logic [6:0]                  rom_addr;
  logic [7:0]                  rom_data;

  config_label_rom u_rom (
    .clk_in   (clk_in),
    .addr_in  (rom_addr),
    .data_out (rom_data)
  );

  assign update_ok = update_in && (field_index_in < NUM_VF);

  // A value stored on this same edge is forwarded so the first digit
  // written already reflects it.
  function automatic logic [7:0] digit_char(input logic [3:0] fi, input logic lo);
    logic [7:0] v;
    v = (update_ok && field_index_in == fi) ? field_value_in : value_file[fi];
    return hex_char(lo ? v[3:0] : v[7:4]);
  endfunction

  function automatic logic [9:0] digit_addr(input logic [3:0] fi, input logic lo);
    return field_addr(fi) + VALUE_COL_OFS + {9'd0, lo};
  endfunction

  // Pending work as seen this cycle; a same-cycle redraw supersedes the update.
  always_comb begin
    eff_redraw = redraw_pend | redraw_in;
    eff_mask   = mask;
    if (update_ok && !redraw_in) eff_mask = mask | (ONE << field_index_in);
    pick = '0;
    for (int i = NUM_VALUE_FIELDS - 1; i >= 0; i--) begin
      if (eff_mask[i]) pick = 4'(i);
    end
  end

  // Next-write logic; outputs are registered, so each state computes the
  // write that appears in the following cycle.
  // NOTE: every signal gets a default first so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    state_nx       = state;
    cnt_nx         = cnt;
    upd_field_nx   = upd_field;
    mask_nx        = eff_mask;
    redraw_pend_nx = redraw_pend | redraw_in;
    en_nx          = 1'b0;
    addr_nx        = '0;
    data_nx        = '0;
    busy_nx        = 1'b0;
    done_nx        = 1'b0;
    rom_addr       = '0;
    f              = '0;
    case (state)
      ST_IDLE: begin
        if (eff_redraw) begin
          en_nx          = 1'b1;
          data_nx        = CHAR_SPACE;
          busy_nx        = 1'b1;
          state_nx       = ST_CLEAR;
          cnt_nx         = 10'd1;
          mask_nx        = '0;
          redraw_pend_nx = 1'b0;
        end else if (|eff_mask) begin
          en_nx        = 1'b1;
          addr_nx      = digit_addr(pick, 1'b0);
          data_nx      = digit_char(pick, 1'b0);
          busy_nx      = 1'b1;
          state_nx     = ST_UPDATE;
          upd_field_nx = pick;
          mask_nx      = eff_mask & ~(ONE << pick);
        end
      end
      ST_CLEAR: begin
        en_nx   = 1'b1;
        addr_nx = cnt;
        data_nx = CHAR_SPACE;
        busy_nx = 1'b1;
        // rom_addr stays 0 here, prefetching the first label character.
        if (cnt == CLEAR_LAST) begin
          state_nx = ST_LABEL;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 10'd1;
        end
      end
      ST_LABEL: begin
        f        = cnt[6:3];
        en_nx    = 1'b1;
        addr_nx  = field_addr(f) + {7'd0, cnt[2:0]};
        data_nx  = rom_data;
        busy_nx  = 1'b1;
        rom_addr = cnt[6:0] + 7'd1;
        if (cnt == LABEL_LAST) begin
          state_nx = ST_VALUE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 10'd1;
        end
      end
      ST_VALUE: begin
        f       = cnt[4:1];
        en_nx   = 1'b1;
        addr_nx = digit_addr(f, cnt[0]);
        data_nx = digit_char(f, cnt[0]);
        busy_nx = 1'b1;
        if (cnt == VALUE_LAST) state_nx = ST_DONE;
        else                   cnt_nx   = cnt + 10'd1;
      end
      ST_UPDATE: begin
        en_nx    = 1'b1;
        addr_nx  = digit_addr(upd_field, 1'b1);
        data_nx  = digit_char(upd_field, 1'b1);
        busy_nx  = 1'b1;
        state_nx = ST_DONE;
      end
      ST_DONE: begin
        done_nx  = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state              <= ST_IDLE;
      cnt                <= '0;
      upd_field          <= '0;
      mask               <= '0;
      redraw_pend        <= 1'b0;
      buf_write_en_out   <= 1'b0;
      buf_write_addr_out <= '0;
      buf_write_data_out <= '0;
      busy_out           <= 1'b0;
      done_out           <= 1'b0;
      // NOTE: the value file is a small register array with a defined
      // power-up content, so it is reset like any other state.
      for (int i = 0; i < NUM_VALUE_FIELDS; i++) value_file[i] <= '0;
    end else begin
      state              <= state_nx;
      cnt                <= cnt_nx;
      upd_field          <= upd_field_nx;
      mask               <= mask_nx;
      redraw_pend        <= redraw_pend_nx;
      buf_write_en_out   <= en_nx;
      buf_write_addr_out <= addr_nx;
      buf_write_data_out <= data_nx;
      busy_out           <= busy_nx;
      done_out           <= done_nx;
      if (update_ok) value_file[field_index_in] <= field_value_in;
    end
  end

endmodule

// File: tb/tb_config_text_writer.sv
// Scoreboard testbench for config_text_writer: expected buffer writes are
// queued when stimulus is driven and compared as the DUT emits them.
module tb_config_text_writer;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b0;
  logic       redraw_in = 1'b0;
  logic       update_in = 1'b0;
  logic [3:0] field_index_in = '0;
  logic [7:0] field_value_in = '0;
  logic       buf_write_en_out;
  logic [9:0] buf_write_addr_out;
  logic [7:0] buf_write_data_out;
  logic       busy_out;
  logic       done_out;

  config_text_writer dut (
    .clk_in             (clk_in),
    .rst_in             (rst_in),
    .redraw_in          (redraw_in),
    .update_in          (update_in),
    .field_index_in     (field_index_in),
    .field_value_in     (field_value_in),
    .buf_write_en_out   (buf_write_en_out),
    .buf_write_addr_out (buf_write_addr_out),
    .buf_write_data_out (buf_write_data_out),
    .busy_out           (busy_out),
    .done_out           (done_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [9:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t   exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    wr_cnt = 0;
  int    first_wr_cyc = 0;
  int    done_cnt = 0;
  int    done_cyc = 0;
  int    req_cyc = 0;
  logic [7:0] mdl_val [12];
  string labels [13] = '{"CH1 GAIN", "CH2 GAIN", "CH3 GAIN", "CH4 GAIN",
                         "CH1 PAN ", "CH2 PAN ", "CH3 PAN ", "CH4 PAN ",
                         "TEMPO   ", "SWING   ", "TRANSPOS", "MASTER  ",
                         "START   "};
  string hexs = "0123456789ABCDEF";

  always @(posedge clk_in) cyc <= cyc + 1;

  // Scoreboard monitor, sampling on the inactive edge.
  always @(negedge clk_in) begin
    wr_t e;
    if (buf_write_en_out === 1'b1) begin
      wr_cnt++;
      if (wr_cnt == 1) first_wr_cyc = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        if (errors < 40)
          $display("FAIL unexpected_write addr=%0d data=%h (none expected)",
                   buf_write_addr_out, buf_write_data_out);
      end else begin
        e = exp_q.pop_front();
        if ({buf_write_addr_out, buf_write_data_out} !== e) begin
          errors++;
          if (errors < 40)
            $display("FAIL write got addr=%0d data=%h want addr=%0d data=%h",
                     buf_write_addr_out, buf_write_data_out, e.a, e.d);
        end
      end
    end
    if (done_out === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
      checks++;
      if (busy_out !== 1'b0 || buf_write_en_out !== 1'b0) begin
        errors++;
        $display("FAIL done_cycle busy=%b en=%b want busy=0 en=0",
                 busy_out, buf_write_en_out);
      end
    end
  end

  function automatic int lbl_addr(input int f);
    int row, col;
    if (f < 8)       begin row = 3 + 2 * f;       col = 2;  end
    else if (f < 12) begin row = 3 + 2 * (f - 8); col = 22; end
    else             begin row = 20;              col = 17; end
    return 40 * row + col;
  endfunction

  task automatic push_wr(input int a, input byte d);
    wr_t w;
    w.a = 10'(a);
    w.d = d;
    exp_q.push_back(w);
  endtask

  task automatic push_digits(input int f);
    push_wr(lbl_addr(f) + 9,  hexs[mdl_val[f][7:4]]);
    push_wr(lbl_addr(f) + 10, hexs[mdl_val[f][3:0]]);
  endtask

  task automatic push_redraw();
    for (int a = 0; a < 920; a++) push_wr(a, 8'h20);
    for (int f = 0; f < 13; f++)
      for (int c = 0; c < 8; c++) push_wr(lbl_addr(f) + c, labels[f][c]);
    for (int f = 0; f < 12; f++) push_digits(f);
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic pulse(input logic rd, input logic up, input logic [3:0] idx,
                       input logic [7:0] val);
    redraw_in      = rd;
    update_in      = up;
    field_index_in = idx;
    field_value_in = val;
    if (up && idx < 12) mdl_val[idx] = val;
    tick();
    req_cyc   = cyc;
    redraw_in = 1'b0;
    update_in = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    int k = 0;
    while (done_cnt < target && k < budget) begin
      tick();
      k++;
    end
    checks++;
    if (done_cnt < target) begin
      errors++;
      $display("FAIL %s timeout done_cnt=%0d want %0d", name, done_cnt, target);
    end
  endtask

  task automatic expect_quiet(input int n, input string name);
    int d0 = done_cnt;
    int w0 = wr_cnt;
    for (int i = 0; i < n; i++) begin
      tick();
      checks++;
      if (busy_out !== 1'b0) begin
        errors++;
        $display("FAIL %s busy=%b want 0", name, busy_out);
      end
    end
    checks++;
    if (done_cnt != d0 || wr_cnt != w0) begin
      errors++;
      $display("FAIL %s extra activity done=%0d writes=%0d want 0/0",
               name, done_cnt - d0, wr_cnt - w0);
    end
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s pending_expected=%0d want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_in    = 1'b0;
    redraw_in = 1'b1;
    repeat (3) tick();
    checks++;
    if ({buf_write_en_out, buf_write_addr_out, buf_write_data_out, busy_out, done_out} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got en=%b addr=%0d data=%h busy=%b done=%b want all 0",
               buf_write_en_out, buf_write_addr_out, buf_write_data_out, busy_out, done_out);
    end
    redraw_in = 1'b0;
    rst_in    = 1'b1;
    for (int i = 0; i < 12; i++) mdl_val[i] = 8'h00;
    expect_quiet(5, "reset_idle");
  endtask

  task automatic test_redraw();
    int d0 = done_cnt;
    push_redraw();
    wr_cnt = 0;
    pulse(1'b1, 1'b0, 4'd0, 8'h00);
    wait_done(d0 + 1, 1200, "redraw");
    checks++;
    if (wr_cnt != 1048) begin
      errors++;
      $display("FAIL redraw_write_count got %0d want 1048", wr_cnt);
    end
    checks++;
    if (first_wr_cyc != req_cyc) begin
      errors++;
      $display("FAIL redraw_first_write cycle got %0d want %0d", first_wr_cyc - req_cyc + 1, 1);
    end
    checks++;
    if (done_cyc - req_cyc + 1 != 1049) begin
      errors++;
      $display("FAIL redraw_done_cycle got %0d want 1049", done_cyc - req_cyc + 1);
    end
    check_drained("redraw");
  endtask

  task automatic test_update();
    int d0 = done_cnt;
    wr_cnt = 0;
    mdl_val[3] = 8'hA7;
    push_digits(3);
    pulse(1'b0, 1'b1, 4'd3, 8'hA7);
    wait_done(d0 + 1, 20, "update");
    checks++;
    if (done_cyc - req_cyc + 1 != 3 || wr_cnt != 2) begin
      errors++;
      $display("FAIL update_timing done_cycle=%0d writes=%0d want 3/2",
               done_cyc - req_cyc + 1, wr_cnt);
    end
    check_drained("update");
  endtask

  task automatic test_update_during_clear();
    int d0 = done_cnt;
    mdl_val[9] = 8'h05;
    push_redraw();
    push_digits(9);
    pulse(1'b1, 1'b0, 4'd0, 8'h00);
    repeat (10) tick();
    pulse(1'b0, 1'b1, 4'd9, 8'h05);
    wait_done(d0 + 2, 1300, "update_during_clear");
    check_drained("update_during_clear");
    expect_quiet(10, "update_during_clear_quiet");
  endtask

  task automatic test_same_cycle();
    int d0 = done_cnt;
    mdl_val[0] = 8'hFF;
    push_redraw();
    pulse(1'b1, 1'b1, 4'd0, 8'hFF);
    wait_done(d0 + 1, 1200, "same_cycle");
    check_drained("same_cycle");
    expect_quiet(20, "same_cycle_no_update");
  endtask

  task automatic test_reset_mid();
    int k = 0;
    int d0 = done_cnt;
    push_redraw();
    wr_cnt = 0;
    pulse(1'b1, 1'b0, 4'd0, 8'h00);
    while (wr_cnt < 500 && k < 1000) begin
      tick();
      k++;
    end
    rst_in = 1'b0;
    tick();
    rst_in = 1'b1;
    checks++;
    if (buf_write_en_out !== 1'b0 || busy_out !== 1'b0 || done_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid got en=%b busy=%b done=%b want 0/0/0",
               buf_write_en_out, busy_out, done_out);
    end
    exp_q.delete();
    for (int i = 0; i < 12; i++) mdl_val[i] = 8'h00;
    expect_quiet(30, "reset_mid_abandon");
    checks++;
    if (done_cnt != d0) begin
      errors++;
      $display("FAIL reset_mid_done got %0d pulses want 0", done_cnt - d0);
    end
  endtask

  task automatic test_ignored_index();
    pulse(1'b0, 1'b1, 4'd12, 8'h5A);
    expect_quiet(5, "ignore_idx12");
    pulse(1'b0, 1'b1, 4'd15, 8'hC3);
    expect_quiet(5, "ignore_idx15");
  endtask

  task automatic test_back_to_back();
    int d0 = done_cnt;
    // Pending updates are served lowest index first, with the latest value.
    mdl_val[2] = 8'h3C;
    push_digits(2);
    mdl_val[1] = 8'h22;
    push_digits(1);
    mdl_val[5] = 8'h9E;
    push_digits(5);
    pulse(1'b0, 1'b1, 4'd2, 8'h3C);
    pulse(1'b0, 1'b1, 4'd5, 8'h11);
    pulse(1'b0, 1'b1, 4'd1, 8'h22);
    pulse(1'b0, 1'b1, 4'd5, 8'h9E);
    wait_done(d0 + 3, 50, "b2b_updates");
    check_drained("b2b_updates");
    expect_quiet(10, "b2b_updates_quiet");
    // A pending redraw wins and discards the pending update mask.
    d0 = done_cnt;
    mdl_val[4] = 8'h44;
    push_digits(4);
    mdl_val[7] = 8'h77;
    push_redraw();
    pulse(1'b0, 1'b1, 4'd4, 8'h44);
    pulse(1'b0, 1'b1, 4'd7, 8'h77);
    pulse(1'b1, 1'b0, 4'd0, 8'h00);
    wait_done(d0 + 2, 1300, "b2b_redraw_priority");
    check_drained("b2b_redraw_priority");
    expect_quiet(20, "b2b_redraw_no_update");
  endtask

  initial begin
    for (int i = 0; i < 12; i++) mdl_val[i] = 8'h00;
    test_reset();
    test_redraw();
    test_update();
    test_update_during_clear();
    test_same_cycle();
    test_ignored_index();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
